// File: rtl/dct_feed_sequencer.sv
// rtl/dct_feed_sequencer.sv - ping-pong sample buffer and skewed DCT-II feed for a 4-PE systolic column
module dct_feed_sequencer #(
  parameter int DW  = 16,
  parameter int NPT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  output logic                 arr_clr,
  output logic signed [DW-1:0] in_north0,
  output logic signed [DW-1:0] in_west0,
  output logic signed [DW-1:0] in_west1,
  output logic signed [DW-1:0] in_west2,
  output logic signed [DW-1:0] in_west3,
  output logic                 busy,
  output logic                 res_valid
);

  if (DW != 16 || NPT != 4) begin : g_param_check
    $error("dct_feed_sequencer: only DW=16 and NPT=4 are supported");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_REPORT
  } state_t;

  // Last feed step: PE3 sees its final coefficient NPT-1 cycles after PE0.
  localparam logic [2:0] FEED_LAST = 3'd6;

  // Q1.14 DCT-II basis C[k][n]
  function automatic logic signed [15:0] basis(input logic [1:0] k, input logic [1:0] n);
    logic signed [15:0] c;
    case (k)
      2'd0: c = 16'sd8192;
      2'd1: begin
        case (n)
          2'd0:    c = 16'sd10703;
          2'd1:    c = 16'sd4433;
          2'd2:    c = -16'sd4433;
          default: c = -16'sd10703;
        endcase
      end
      2'd2: c = (n == 2'd0 || n == 2'd3) ? 16'sd8192 : -16'sd8192;
      default: begin
        case (n)
          2'd0:    c = 16'sd4433;
          2'd1:    c = -16'sd10703;
          2'd2:    c = 16'sd10703;
          default: c = -16'sd4433;
        endcase
      end
    endcase
    return c;
  endfunction

  // Row k is skewed by k cycles so PEk meets x[n] together with C[k][n].
  function automatic logic signed [15:0] west_coef(input logic [1:0] k, input logic [2:0] t);
    logic [2:0] n;
    n = t - {1'b0, k};
    if (t >= {1'b0, k} && n <= 3'd3) begin
      return basis(k, n[1:0]);
    end
    return '0;
  endfunction

  state_t               state_q, state_d;
  logic [2:0]           t_q, t_d;
  logic [1:0]           full_q, full_d;
  logic                 wr_bank_q, wr_bank_d;
  logic [1:0]           wr_idx_q, wr_idx_d;
  logic                 rd_bank_q, rd_bank_d;
  logic                 s_ready_q, s_ready_d;
  logic                 arr_clr_q, arr_clr_d;
  logic                 busy_q, busy_d;
  logic                 res_valid_q, res_valid_d;
  logic signed [DW-1:0] north_q, north_d;
  logic signed [DW-1:0] west0_q, west0_d;
  logic signed [DW-1:0] west1_q, west1_d;
  logic signed [DW-1:0] west2_q, west2_d;
  logic signed [DW-1:0] west3_q, west3_d;

  logic signed [DW-1:0] bank_mem [2][NPT];
  logic                 accept;

  assign accept = s_valid & s_ready_q;

  // Next-state, bank bookkeeping and registered-output values
  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_bank_d   = rd_bank_q;
    state_d     = state_q;
    t_d         = t_q;
    north_d     = '0;
    west0_d     = '0;
    west1_d     = '0;
    west2_d     = '0;
    west3_d     = '0;

    if (accept) begin
      wr_idx_d = wr_idx_q + 2'd1;
      if (wr_idx_q == 2'(NPT - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    // IDLE looks at full_d so a block completing this cycle starts CLEAR next cycle;
    // REPORT does the same for the other bank to keep blocks back-to-back.
    case (state_q)
      ST_IDLE: begin
        if (full_d[rd_bank_q]) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_FEED;
        t_d     = '0;
      end
      ST_FEED: begin
        if (t_q == FEED_LAST) state_d = ST_REPORT;
        else                  t_d     = t_q + 3'd1;
      end
      ST_REPORT: begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        state_d           = full_d[~rd_bank_q] ? ST_CLEAR : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    s_ready_d   = ~full_d[wr_bank_d];
    arr_clr_d   = (state_d == ST_CLEAR);
    busy_d      = (state_d != ST_IDLE);
    res_valid_d = (state_d == ST_REPORT);

    if (state_d == ST_FEED) begin
      if (t_d < 3'(NPT)) north_d = bank_mem[rd_bank_q][t_d[1:0]];
      west0_d = west_coef(2'd0, t_d);
      west1_d = west_coef(2'd1, t_d);
      west2_d = west_coef(2'd2, t_d);
      west3_d = west_coef(2'd3, t_d);
    end
  end

  // Control state and registered outputs; reset discards both banks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      t_q         <= '0;
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      s_ready_q   <= 1'b0;
      arr_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      north_q     <= '0;
      west0_q     <= '0;
      west1_q     <= '0;
      west2_q     <= '0;
      west3_q     <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_bank_q   <= rd_bank_d;
      s_ready_q   <= s_ready_d;
      arr_clr_q   <= arr_clr_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      north_q     <= north_d;
      west0_q     <= west0_d;
      west1_q     <= west1_d;
      west2_q     <= west2_d;
      west3_q     <= west3_d;
    end
  end

  // Sample storage; contents only matter once a bank is marked full
  always_ff @(posedge clk) begin
    if (accept) bank_mem[wr_bank_q][wr_idx_q] <= s_data;
  end

  assign s_ready   = s_ready_q;
  assign arr_clr   = arr_clr_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign in_north0 = north_q;
  assign in_west0  = west0_q;
  assign in_west1  = west1_q;
  assign in_west2  = west2_q;
  assign in_west3  = west3_q;

endmodule

// File: tb/tb_dct_feed_sequencer.sv
// tb/tb_dct_feed_sequencer.sv - randomized self-checking bench for dct_feed_sequencer
module tb_dct_feed_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_data;
  logic               arr_clr;
  logic signed [15:0] in_north0, in_west0, in_west1, in_west2, in_west3;
  logic               busy;
  logic               res_valid;

  dct_feed_sequencer #(.DW(16), .NPT(4)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .arr_clr(arr_clr), .in_north0(in_north0), .in_west0(in_west0), .in_west1(in_west1),
    .in_west2(in_west2), .in_west3(in_west3), .busy(busy), .res_valid(res_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference basis from the DCT-II definition, scaled to Q1.14 and rounded
  int basis_tab [4][4];

  typedef struct { int x[4]; } blk_t;

  blk_t   pend_q[$];
  blk_t   cur;
  int     part [4];
  int     part_n, complete, reported;
  bit     in_blk, exp_clr, settle;
  int     cyc, clr_cyc, feed_t, n_clr, n_res;
  int     dd, tt;
  longint acc [4];
  longint last_res [4];
  longint nh [7];
  longint w [4];
  longint ref_y;
  int     res_cyc_q[$];
  int     txq[$];
  int     stall_cnt;

  function automatic longint exp_west(input int k, input int t);
    if (t - k >= 0 && t - k <= 3) return basis_tab[k][t-k];
    return 0;
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "_north0"}, in_north0, 0);
    check_eq({tag, "_west0"}, in_west0, 0);
    check_eq({tag, "_west1"}, in_west1, 0);
    check_eq({tag, "_west2"}, in_west2, 0);
    check_eq({tag, "_west3"}, in_west3, 0);
  endtask

  // Reference model: block queue, bank occupancy and a behavioural PE column
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend_q.delete();
      part_n   = 0;
      complete = 0;
      reported = 0;
      in_blk   = 0;
      exp_clr  = 0;
      feed_t   = -1;
      settle   = 1;
    end else begin
      check_eq("s_ready", s_ready, settle ? 0 : (((complete - reported) < 2) ? 1 : 0));
      settle = 0;
      feed_t = -1;
      if (exp_clr) check_eq("clr_latency", arr_clr, 1);
      if (arr_clr) begin
        n_clr++;
        check_eq("clr_has_block", (pend_q.size() > 0) ? 1 : 0, 1);
        check_eq("clr_busy", busy, 1);
        check_eq("clr_res_valid", res_valid, 0);
        check_quiet("clr");
        if (pend_q.size() > 0) begin
          cur     = pend_q.pop_front();
          in_blk  = 1;
          clr_cyc = cyc;
          acc     = '{default: 0};
        end
      end else if (in_blk) begin
        dd = cyc - clr_cyc;
        check_eq("blk_busy", busy, 1);
        if (dd <= 7) begin
          tt     = dd - 1;
          feed_t = tt;
          check_eq("res_valid_early", res_valid, 0);
          check_eq("in_north0", in_north0, (tt < 4) ? cur.x[tt] : 0);
          nh[tt] = in_north0;
          w[0] = in_west0; w[1] = in_west1; w[2] = in_west2; w[3] = in_west3;
          for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("in_west%0d_t%0d", k, tt), w[k], exp_west(k, tt));
            // PEk sees the sample stream k cycles after PE0
            if (tt - k >= 0) acc[k] += w[k] * nh[tt-k];
          end
        end else begin
          check_eq("res_valid", res_valid, 1);
          check_quiet("report");
          for (int k = 0; k < 4; k++) begin
            ref_y = 0;
            for (int n = 0; n < 4; n++) ref_y += longint'(basis_tab[k][n]) * cur.x[n];
            check_eq($sformatf("result%0d", k), acc[k], ref_y);
          end
          last_res = acc;
          res_cyc_q.push_back(cyc);
          n_res++;
          in_blk = 0;
          reported++;
        end
      end else begin
        check_eq("idle_busy", busy, 0);
        check_eq("idle_res_valid", res_valid, 0);
      end
      if (s_valid && s_ready) begin
        part[part_n] = s_data;
        part_n++;
        if (part_n == 4) begin
          blk_t nb;
          nb.x = part;
          pend_q.push_back(nb);
          complete++;
          part_n = 0;
        end
      end
      exp_clr = !in_blk && (pend_q.size() > 0);
    end
  end

  task automatic send_one(input int v, input int gap);
    bit r;
    bit ok;
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    s_valid = 1'b1;
    s_data  = 16'(v);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      r = s_ready;
      @(posedge clk); #1;
      if (r) begin ok = 1; break; end
      stall_cnt++;
    end
    if (!ok) check_eq("handshake_timeout", 0, 1);
  endtask

  task automatic send_all(input int gap_max);
    for (int i = 0; i < txq.size(); i++)
      send_one(txq[i], (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0)));
    s_valid = 1'b0;
  endtask

  task automatic wait_results(input int tgt);
    for (int i = 0; i < 500 && n_res < tgt; i++) begin @(negedge clk); #1; end
    check_eq("result_arrives", (n_res >= tgt) ? 1 : 0, 1);
    @(posedge clk); #1;
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(65535, 0)) - 32768;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int     tgt, base, n0;
    real    pi, sc, v;
    longint exp_r [4];

    pi = 3.14159265358979;
    for (int k = 0; k < 4; k++)
      for (int n = 0; n < 4; n++) begin
        sc = (k == 0) ? 0.5 : $sqrt(0.5);
        v  = 16384.0 * sc * $cos(real'((2 * n + 1) * k) * pi / 8.0);
        basis_tab[k][n] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
      end

    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_arr_clr", arr_clr, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_s_ready", s_ready, 0);
    check_quiet("rst");
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("s_ready_after_rst", s_ready, 1);

    // Single block [1,2,3,4]
    tgt = n_res + 1;
    txq = '{1, 2, 3, 4};
    send_all(0);
    wait_results(tgt);
    exp_r = '{81920, -36542, 0, -2596};
    for (int k = 0; k < 4; k++) check_eq($sformatf("s1_result%0d", k), last_res[k], exp_r[k]);

    // Three blocks back-to-back with s_valid held high
    stall_cnt = 0;
    base = res_cyc_q.size();
    tgt  = n_res + 3;
    txq.delete();
    for (int i = 0; i < 12; i++) txq.push_back(rnd_sample());
    send_all(0);
    wait_results(tgt);
    check_eq("b2b_stall_cycles", stall_cnt, 5);
    check_eq("b2b_period_1", res_cyc_q[base+1] - res_cyc_q[base], 9);
    check_eq("b2b_period_2", res_cyc_q[base+2] - res_cyc_q[base+1], 9);

    // Most-negative samples
    tgt = n_res + 1;
    txq = '{-32768, -32768, -32768, -32768};
    send_all(0);
    wait_results(tgt);
    exp_r = '{-1073741824, 0, 0, 0};
    for (int k = 0; k < 4; k++) check_eq($sformatf("s4_result%0d", k), last_res[k], exp_r[k]);

    // Reset during FEED t=3 with a partial block in the other bank
    txq = '{5, 6, 7, 8, 9, 10};
    send_all(0);
    for (int i = 0; i < 50 && feed_t != 3; i++) begin @(negedge clk); #1; end
    check_eq("s5_reached_t3", feed_t, 3);
    check_eq("s5_north_t3", in_north0, 8);
    check_eq("s5_west3_t3", in_west3, 4433);
    rst = 1'b1;
    #1;
    check_eq("s5_arr_clr", arr_clr, 0);
    check_eq("s5_busy", busy, 0);
    check_eq("s5_res_valid", res_valid, 0);
    check_eq("s5_s_ready", s_ready, 0);
    check_quiet("s5");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("s5_s_ready_release", s_ready, 1);
    tgt = n_res + 1;
    txq = '{1, 2, 3, 4};
    send_all(0);
    wait_results(tgt);
    exp_r = '{81920, -36542, 0, -2596};
    for (int k = 0; k < 4; k++) check_eq($sformatf("s5_result%0d", k), last_res[k], exp_r[k]);

    // Partial block stalls: three samples, long gap, then the fourth
    n0  = n_clr;
    txq = '{rnd_sample(), rnd_sample(), rnd_sample()};
    send_all(3);
    repeat (40) begin @(posedge clk); #1; end
    check_eq("s6_no_clr_partial", n_clr, n0);
    check_eq("s6_s_ready", s_ready, 1);
    tgt = n_res + 1;
    txq = '{rnd_sample()};
    send_all(0);
    wait_results(tgt);

    // Random blocks with random valid gaps
    tgt = n_res + 6;
    for (int b = 0; b < 6; b++) begin
      txq = '{rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample()};
      send_all(2);
    end
    wait_results(tgt);
    check_eq("pending_empty", pend_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
